// File: rtl/stack_alu_sequencer.sv
// Operand-stack controller feeding an external combinational 8-bit ALU.
// Optional zero_flag output enabled by defining STACK_ALU_ZFLAG_EN.
package stack_alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_MUL = 4'd7,
    OP_INC = 4'd8,
    OP_DEC = 4'd9,
    OP_NEG = 4'd10,
    OP_NOT = 4'd11
  } alu_op_e;

  localparam logic [1:0] KIND_PUSH = 2'b00;
  localparam logic [1:0] KIND_ALU  = 2'b01;
  localparam logic [1:0] KIND_POP  = 2'b10;
  localparam logic [1:0] KIND_DUP  = 2'b11;

  // Undefined encodings fall through as binary.
  function automatic logic is_unary(input alu_op_e op);
    return (op == OP_INC) || (op == OP_DEC) || (op == OP_NEG) || (op == OP_NOT);
  endfunction
endpackage

module stack_alu_sequencer
  import stack_alu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_kind,
  input  alu_op_e                  cmd_op,
  input  logic [DW-1:0]            cmd_imm,
  output logic [DW-1:0]            alu_a,
  output logic [DW-1:0]            alu_b,
  output alu_op_e                  alu_op,
  input  logic [DW-1:0]            alu_out,
  output logic [DW-1:0]            tos,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     busy,
  output logic                     err_underflow,
  output logic                     err_overflow,
`ifdef STACK_ALU_ZFLAG_EN
  output logic                     zero_flag,
`endif
  input  logic                     clr_err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int DPW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_POP_B, S_POP_A, S_EXEC, S_PUSH_R} state_e;

  state_e          state_reg, state_next;
  logic [DW-1:0]   mem [DEPTH];
  logic [DPW-1:0]  depth_reg;
  logic [DW-1:0]   b_reg, res_reg;
  alu_op_e         op_reg;

  logic [AW-1:0]   wr_idx, top_idx;
  logic            accept, empty, full, op_unary;
  logic            push_en, pop_en, set_unf, set_ovf, load_alu;
  logic [DW-1:0]   push_data, alu_a_next, alu_b_next;

  // The write slot's low bits minus one wrap correctly to the top entry even when full.
  assign wr_idx    = depth_reg[AW-1:0];
  assign top_idx   = wr_idx - AW'(1);
  assign empty     = (depth_reg == '0);
  assign full      = (depth_reg == DPW'(DEPTH));
  assign tos       = empty ? '0 : mem[top_idx];
  assign depth     = depth_reg;
  assign cmd_ready = (state_reg == S_IDLE);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign op_unary  = is_unary(op_reg);

  always_comb begin
    state_next = state_reg;
    push_en    = 1'b0;
    push_data  = cmd_imm;
    pop_en     = 1'b0;
    set_unf    = 1'b0;
    set_ovf    = 1'b0;
    load_alu   = 1'b0;
    alu_a_next = '0;
    alu_b_next = b_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          case (cmd_kind)
            KIND_PUSH: begin
              if (full) set_ovf = 1'b1;
              else      push_en = 1'b1;
            end
            KIND_POP: begin
              if (empty) set_unf = 1'b1;
              else       pop_en  = 1'b1;
            end
            KIND_DUP: begin
              if (empty)     set_unf = 1'b1;
              else if (full) set_ovf = 1'b1;
              else begin
                push_en   = 1'b1;
                push_data = tos;
              end
            end
            default: begin
              if (empty || (!is_unary(cmd_op) && depth_reg < DPW'(2))) set_unf = 1'b1;
              else state_next = S_POP_B;
            end
          endcase
        end
      end
      S_POP_B: begin
        pop_en = 1'b1;
        if (op_unary) begin
          load_alu   = 1'b1;
          alu_b_next = tos;
          state_next = S_EXEC;
        end else begin
          state_next = S_POP_A;
        end
      end
      S_POP_A: begin
        pop_en     = 1'b1;
        load_alu   = 1'b1;
        alu_a_next = tos;
        state_next = S_EXEC;
      end
      S_EXEC:   state_next = S_PUSH_R;
      S_PUSH_R: begin
        push_en    = 1'b1;
        push_data  = res_reg;
        state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  // ALU operand registers load on entry to EXEC so they are stable for the whole EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      depth_reg     <= '0;
      b_reg         <= '0;
      res_reg       <= '0;
      op_reg        <= OP_ADD;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= OP_ADD;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (push_en)     depth_reg <= depth_reg + DPW'(1);
      else if (pop_en) depth_reg <= depth_reg - DPW'(1);
      if (state_reg == S_IDLE && state_next == S_POP_B) op_reg <= cmd_op;
      if (state_reg == S_POP_B) b_reg <= tos;
      if (load_alu) begin
        alu_a  <= alu_a_next;
        alu_b  <= alu_b_next;
        alu_op <= op_reg;
      end
      if (state_reg == S_EXEC) res_reg <= alu_out;
      err_underflow <= (err_underflow && !clr_err) || set_unf;
      err_overflow  <= (err_overflow  && !clr_err) || set_ovf;
    end
  end

`ifdef STACK_ALU_ZFLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     zero_flag <= 1'b0;
    else if (state_reg == S_PUSH_R) zero_flag <= (res_reg == '0);
  end
`endif

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_idx] <= push_data;
  end

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Bench for stack_alu_sequencer: queue-based stack model checked every cycle,
// directed scenarios with literal expectations, then randomized commands.
module tb_stack_alu_sequencer;
  import stack_alu_pkg::*;

  localparam int DEPTH = 8;
  localparam int DPW   = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           cmd_valid, cmd_ready, busy, err_underflow, err_overflow, clr_err;
  logic [1:0]     cmd_kind;
  alu_op_e        cmd_op, alu_op;
  logic [7:0]     cmd_imm, alu_a, alu_b, alu_out, tos;
  logic [DPW-1:0] depth;
`ifdef STACK_ALU_ZFLAG_EN
  logic           zero_flag;
`endif

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input alu_op_e op);
    logic [7:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SHL:  r = a << b[2:0];
      OP_SHR:  r = a >> b[2:0];
      OP_MUL:  r = a * b;
      OP_INC:  r = b + 8'd1;
      OP_DEC:  r = b - 8'd1;
      OP_NEG:  r = 8'd0 - b;
      OP_NOT:  r = ~b;
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  function automatic bit is_un(input alu_op_e op);
    return op == OP_INC || op == OP_DEC || op == OP_NEG || op == OP_NOT;
  endfunction

  assign alu_out = alu_fn(alu_a, alu_b, alu_op);

  stack_alu_sequencer #(.DEPTH(DEPTH), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_op(cmd_op), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .tos(tos), .depth(depth), .busy(busy),
    .err_underflow(err_underflow), .err_overflow(err_overflow),
`ifdef STACK_ALU_ZFLAG_EN
    .zero_flag(zero_flag),
`endif
    .clr_err(clr_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue is the stack; an ALU command pops one per cycle,
  // spends one cycle evaluating, then pushes the result.
  logic [7:0] stk[$];
  int         phase, nops;
  logic [7:0] m_a, m_b, m_res, e_alu_a, e_alu_b;
  alu_op_e    m_op, e_alu_op;
  logic       e_unf, e_ovf, e_zf;
  bit         run_cmp = 1'b0;

  task automatic model_reset();
    stk.delete();
    phase = 0; nops = 0;
    e_alu_a = 8'd0; e_alu_b = 8'd0; e_alu_op = OP_ADD;
    e_unf = 1'b0; e_ovf = 1'b0; e_zf = 1'b0;
  endtask

  task automatic model_update();
    logic n_unf, n_ovf;
    n_unf = 1'b0; n_ovf = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (phase != 0) begin
      if (phase <= nops) begin
        void'(stk.pop_back());
        if (phase == nops) begin
          e_alu_a = m_a; e_alu_b = m_b; e_alu_op = m_op;
        end
        phase++;
      end else if (phase == nops + 1) begin
        phase++;
      end else begin
        stk.push_back(m_res);
        e_zf = (m_res == 8'd0);
        phase = 0;
      end
    end else if (cmd_valid) begin
      case (cmd_kind)
        2'b00: if (stk.size() == DEPTH) n_ovf = 1'b1; else stk.push_back(cmd_imm);
        2'b10: if (stk.size() == 0) n_unf = 1'b1; else void'(stk.pop_back());
        2'b11: begin
          if (stk.size() == 0) n_unf = 1'b1;
          else if (stk.size() == DEPTH) n_ovf = 1'b1;
          else stk.push_back(stk[stk.size()-1]);
        end
        default: begin
          nops = is_un(cmd_op) ? 1 : 2;
          if (stk.size() < nops) n_unf = 1'b1;
          else begin
            m_op  = cmd_op;
            m_b   = stk[stk.size()-1];
            m_a   = (nops == 2) ? stk[stk.size()-2] : 8'd0;
            m_res = alu_fn(m_a, m_b, m_op);
            phase = 1;
          end
        end
      endcase
    end
    e_unf = (e_unf && !clr_err) || n_unf;
    e_ovf = (e_ovf && !clr_err) || n_ovf;
  endtask

  always @(negedge clk) begin : cmp
    logic [7:0] et;
    if (run_cmp) begin
      et = (stk.size() != 0) ? stk[stk.size()-1] : 8'd0;
      check("cmd_ready", cmd_ready, phase == 0);
      check("busy", busy, phase != 0);
      check("depth", depth, stk.size());
      check("tos", tos, et);
      check("alu_a", alu_a, e_alu_a);
      check("alu_b", alu_b, e_alu_b);
      check("alu_op", alu_op, e_alu_op);
      check("err_underflow", err_underflow, e_unf);
      check("err_overflow", err_overflow, e_ovf);
`ifdef STACK_ALU_ZFLAG_EN
      check("zero_flag", zero_flag, e_zf);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic send(input logic [1:0] k, input alu_op_e op, input logic [7:0] imm,
                      input bit junk, output int lat);
    cmd_valid = 1'b1; cmd_kind = k; cmd_op = op; cmd_imm = imm;
    step();
    cmd_valid = 1'b0;
    lat = 0;
    while (cmd_ready !== 1'b1 && lat < 20) begin
      if (junk) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_kind  = 2'($urandom);
        cmd_op    = alu_op_e'(4'($urandom));
        cmd_imm   = 8'($urandom);
        clr_err   = ($urandom_range(0, 7) == 0);
      end
      lat++;
      step();
    end
    cmd_valid = 1'b0;
    clr_err   = 1'b0;
    if (lat >= 20) check("ready_timeout", lat, 0);
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    cmd_valid = 1'b0; cmd_kind = 2'b00; cmd_op = OP_ADD; cmd_imm = 8'd0; clr_err = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 run_cmp = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_depth", depth, 0);
    check("rst_tos", tos, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_op", alu_op, OP_ADD);
    check("rst_errs", {err_underflow, err_overflow}, 0);
    rst_n = 1'b1;

    // SUB: 5 - 3
    send(2'b00, OP_ADD, 8'd5, 0, lat);
    send(2'b00, OP_ADD, 8'd3, 0, lat);
    send(2'b01, OP_SUB, 8'd0, 0, lat);
    check("sub_latency", lat, 4);
    check("sub_tos", tos, 2);
    check("sub_depth", depth, 1);
    check("sub_alu_a", alu_a, 5);
    check("sub_alu_b", alu_b, 3);
    check("sub_alu_op", alu_op, OP_SUB);
    send(2'b10, OP_ADD, 8'd0, 0, lat);

    // INC wraps FF -> 00
    send(2'b00, OP_ADD, 8'hFF, 0, lat);
    send(2'b01, OP_INC, 8'd0, 0, lat);
    check("inc_latency", lat, 3);
    check("inc_tos", tos, 0);
    check("inc_depth", depth, 1);
    check("inc_alu_a", alu_a, 0);
`ifdef STACK_ALU_ZFLAG_EN
    check("inc_zero_flag", zero_flag, 1);
`endif
    send(2'b10, OP_ADD, 8'd0, 0, lat);

    // Binary ALU with a single operand
    send(2'b00, OP_ADD, 8'd7, 0, lat);
    send(2'b01, OP_ADD, 8'd0, 0, lat);
    check("unf_latency", lat, 0);
    check("unf_flag", err_underflow, 1);
    check("unf_depth", depth, 1);
    check("unf_tos", tos, 7);
    clear_errors();
    check("unf_cleared", err_underflow, 0);
    send(2'b10, OP_ADD, 8'd0, 0, lat);

    // Fill, then overflow via PUSH and DUP
    for (int i = 1; i <= DEPTH; i++) send(2'b00, OP_ADD, 8'(i), 0, lat);
    send(2'b00, OP_ADD, 8'd9, 0, lat);
    check("ovf_flag", err_overflow, 1);
    check("ovf_depth", depth, 8);
    check("ovf_tos", tos, 8);
    clear_errors();
    check("ovf_cleared", err_overflow, 0);
    send(2'b11, OP_ADD, 8'd0, 0, lat);
    check("dup_ovf_flag", err_overflow, 1);
    send(2'b10, OP_ADD, 8'd0, 0, lat);
    check("pop_depth", depth, 7);
    check("pop_tos", tos, 7);
    for (int i = 0; i < 7; i++) send(2'b10, OP_ADD, 8'd0, 0, lat);
    clear_errors();
    // clear and a new error in the same cycle: new error wins
    clr_err = 1'b1;
    send(2'b10, OP_ADD, 8'd0, 0, lat);
    check("clr_vs_new_err", err_underflow, 1);
    clear_errors();

    // DUP then MUL: 6*6
    send(2'b00, OP_ADD, 8'd6, 0, lat);
    send(2'b11, OP_ADD, 8'd0, 0, lat);
    send(2'b01, OP_MUL, 8'd0, 0, lat);
    check("mul_tos", tos, 36);
    check("mul_depth", depth, 1);
    send(2'b10, OP_ADD, 8'd0, 0, lat);
    send(2'b10, OP_ADD, 8'd0, 0, lat);
    check("pop_empty_unf", err_underflow, 1);
    check("pop_empty_depth", depth, 0);
    check("pop_empty_tos", tos, 0);
    clear_errors();

    // Reset during POP_A
    send(2'b00, OP_ADD, 8'd4, 0, lat);
    send(2'b00, OP_ADD, 8'd2, 0, lat);
    cmd_valid = 1'b1; cmd_kind = 2'b01; cmd_op = OP_SHL;
    step();
    cmd_valid = 1'b0;
    step();
    check("popa_depth", depth, 1);
    check("popa_busy", busy, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_depth", depth, 0);
    check("midrst_busy", busy, 0);
    check("midrst_errs", {err_underflow, err_overflow}, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    check("midrst_ready", cmd_ready, 1);
    check("midrst_no_push", depth, 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) < 2) begin
        clr_err = ($urandom_range(0, 7) == 0);
        step();
        clr_err = 1'b0;
      end else begin
        clr_err = ($urandom_range(0, 9) == 0);
        send(2'($urandom), alu_op_e'(4'($urandom_range(0, 15))), 8'($urandom), 1, lat);
      end
    end

    step();
    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stack_alu_sequencer.md
Name: stack_alu_sequencer

Overview:
Operand-stack controller for the stack machine's 8-bit ALU. It holds a LIFO operand stack and accepts PUSH/POP/DUP/ALU commands over a valid/ready handshake. For ALU commands it pops one or two operands, drives the external combinational ALU, and pushes the result back. It sits between the instruction decoder and the ALU, and reports depth, top-of-stack and sticky error flags.

Parameters:
DEPTH, 8, number of stack entries; power of two, >= 2.
DW, 8, data width; fixed to match the ALU, not to be overridden.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset, asynchronous, active-low.
cmd_valid  in  1  command offered.
cmd_ready  out  1  block can accept a command this cycle.
cmd_kind  in  2  00 PUSH, 01 ALU, 10 POP (discard top), 11 DUP.
cmd_op  in  alu_op_e  ALU operation, used only when cmd_kind=01.
cmd_imm  in  8  immediate data for PUSH.
alu_a  out  8  ALU in_a (second-from-top operand).
alu_b  out  8  ALU in_b (top operand).
alu_op  out  alu_op_e  ALU op select.
alu_out  in  8  ALU result, combinational.
tos  out  8  current top of stack; 0 when empty.
depth  out  $clog2(DEPTH)+1  number of valid entries.
busy  out  1  FSM not in IDLE.
err_underflow  out  1  sticky; a command needed more operands than present.
err_overflow  out  1  sticky; push or dup issued when full.
clr_err  in  1  synchronous clear of both sticky errors.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, depth=0, alu_a=alu_b=0, alu_op=ADD, both errors 0, tos=0, busy=0. Stack contents are don't-care. Reset mid-operation abandons the command and no push occurs.
- Handshake: a command is accepted when cmd_valid && cmd_ready. cmd_ready=1 only in IDLE. Inputs are sampled only on the accept edge.
- Unary ops are INC, DEC, NEG and NOT; they need 1 operand. All other ops are binary and need 2.
- PUSH, POP and DUP complete on the accept edge; FSM stays IDLE and the next command can be accepted the following cycle.
  - PUSH: stack[depth] <= cmd_imm; depth+1.
  - POP: depth-1.
  - DUP: stack[depth] <= tos; depth+1.
- Error checks at accept:
  - PUSH or DUP with depth==DEPTH: set err_overflow, no state change.
  - POP or DUP with depth==0: set err_underflow, no state change.
  - ALU with depth < operands needed: set err_underflow, no state change, FSM stays IDLE.
  - ALU commands never overflow (net depth change is <= 0).
- ALU FSM:
  - IDLE -> POP_B on a valid ALU accept; latch op.
  - POP_B: b_reg <= top; depth-1. Next state is POP_A if binary, else EXEC.
  - POP_A: a_reg <= top; depth-1. Next state is EXEC.
  - EXEC: alu_a=a_reg (0 for unary), alu_b=b_reg, alu_op=latched op; res_reg <= alu_out. Next state is PUSH_R.
  - PUSH_R: stack[depth] <= res_reg; depth+1. Next state is IDLE.
- ALU command latency (accept edge to result visible on tos): binary 4 cycles, unary 3. cmd_ready is low for that many cycles.
- alu_a, alu_b and alu_op are registered and hold their last values outside EXEC.
- tos and depth are combinational from the stack and pointer, and update after every push/pop edge, including the intermediate POP states.
- Arithmetic is modulo 2^8; ALU overflow is not flagged.
- Ops outside the defined enum are treated as binary; the result is whatever the ALU returns (0).
- clr_err: if clr_err and a new error occur in the same cycle, the new error wins (flag reads 1).

Optional Feature:
Macro STACK_ALU_ZFLAG_EN.
- Defined: adds output zero_flag (1 bit, reset 0). It is updated on the PUSH_R edge to (res_reg==0), and is unchanged by PUSH, POP and DUP.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- PUSH 5, PUSH 3, ALU SUB -> cmd_ready low 4 cycles; afterwards tos=2, depth=1, alu_a=5, alu_b=3 seen in EXEC; zero_flag=0 if enabled.
- PUSH 8'hFF, ALU INC -> 3-cycle latency; tos=8'h00, depth=1; zero_flag=1 if enabled.
- PUSH 7, ALU ADD (binary with depth 1) -> err_underflow=1, depth=1, tos=7, no busy cycle; clr_err -> err_underflow=0.
- Push DEPTH values 1..8, then PUSH 9 -> err_overflow=1, depth=8, tos=8; DUP also sets overflow; POP -> depth=7, tos=7.
- PUSH 6, DUP, ALU MUL -> tos=36, depth=1; then POP, then POP -> err_underflow=1, depth=0, tos=0.
- PUSH 4, PUSH 2, ALU SHL, with rst_n pulsed low during POP_A -> immediately depth=0, busy=0, errors 0; after release, cmd_ready=1.
